// File: rtl/pwr_sequencer_pkg.sv
// Shared encodings for the power/reset sequencer so the top-level wrapper and
// debug CSRs decode state and reset cause identically.
package pwr_sequencer_pkg;

    typedef enum logic [2:0] {
        PWR_EMBRYO     = 3'd0,
        PWR_DEBOUNCE   = 3'd1,
        PWR_RESET_HOLD = 3'd2,
        PWR_RUNNING    = 3'd3,
        PWR_DRAIN      = 3'd4
    } pwr_state_e;

    localparam logic [1:0] CAUSE_POR      = 2'b00;
    localparam logic [1:0] CAUSE_SOFT     = 2'b01;
    localparam logic [1:0] CAUSE_WDT      = 2'b10;
    localparam logic [1:0] CAUSE_DRAIN_TO = 2'b11;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pwr_sequencer.sv
// Power/reset sequencer: debounces wake_n, holds the SoC in reset after wake or
// watchdog bite, supervises the watchdog in run and drains the UART on poweroff.
module pwr_sequencer
    import pwr_sequencer_pkg::*;
#(
    parameter int unsigned WAKE_DEBOUNCE_CYCLES = 4,
    parameter int unsigned RESET_HOLD_CYCLES    = 8,
    parameter int unsigned DRAIN_TIMEOUT_CYCLES = 64,
    parameter int unsigned WDT_CYCLES           = 256
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wake_n,
    input  logic       poweroff_rq,
    input  logic       tx_idle,
    input  logic       wdt_kick,
    output logic       soc_resetn,
    output logic       io_enable,
    output logic [2:0] state,
    output logic [1:0] reset_cause
);

    localparam int unsigned MAXP = max4(WAKE_DEBOUNCE_CYCLES, RESET_HOLD_CYCLES,
                                        DRAIN_TIMEOUT_CYCLES, WDT_CYCLES);
    localparam int unsigned CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(WAKE_DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RESET_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WDT_LAST   = (WDT_CYCLES == 0) ? '0 : CW'(WDT_CYCLES - 1);
    localparam bit            WDT_EN     = (WDT_CYCLES != 0);

    // State kept as raw bits so the illegal encodings 5-7 stay representable.
    logic [2:0]    state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= PWR_EMBRYO;
            cause_q <= CAUSE_POR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            PWR_EMBRYO: begin
                cnt_d = '0;
                if (!wake_n) state_d = PWR_DEBOUNCE;
            end
            PWR_DEBOUNCE: begin
                if (wake_n) begin
                    state_d = PWR_EMBRYO;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PWR_RESET_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PWR_RESET_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = PWR_RUNNING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PWR_RUNNING: begin
                // Poweroff outranks a bite landing on the same cycle.
                if (poweroff_rq) begin
                    state_d = PWR_DRAIN;
                    cnt_d   = '0;
                end else if (WDT_EN && cnt_q == WDT_LAST && !wdt_kick) begin
                    state_d = PWR_RESET_HOLD;
                    cause_d = CAUSE_WDT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = wdt_kick ? '0 : cnt_q + CW'(1);
                end
            end
            PWR_DRAIN: begin
                if (tx_idle) begin
                    state_d = PWR_EMBRYO;
                    cause_d = CAUSE_SOFT;
                    cnt_d   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = PWR_EMBRYO;
                    cause_d = CAUSE_DRAIN_TO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = PWR_EMBRYO;
                cnt_d   = '0;
            end
        endcase
    end

    assign soc_resetn  = (state_q == PWR_RUNNING) || (state_q == PWR_DRAIN);
    assign io_enable   = (state_q == PWR_RUNNING) || (state_q == PWR_DRAIN);
    assign state       = state_q;
    assign reset_cause = cause_q;

endmodule
